// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC controller: FSM states,
// opcode classes, opcode values, ALU operations and PC source selects.
package multicycle_controller_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CL_R   = 3'd0,
      CL_LW  = 3'd1,
      CL_SW  = 3'd2,
      CL_BNE = 3'd3,
      CL_J   = 3'd4,
      CL_ILL = 3'd5
   } op_class_t;

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd6;
   localparam logic [3:0] OP_SLT = 4'd7;
   localparam logic [3:0] OP_LW  = 4'd8;
   localparam logic [3:0] OP_SW  = 4'd10;
   localparam logic [3:0] OP_BNE = 4'd14;
   localparam logic [3:0] OP_J   = 4'd15;

   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;
   localparam logic [2:0] ALU_SLT = 3'd7;

   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_controller_opcode_decoder.sv
// Combinational opcode decode: instruction class, ALU operation and legality.
module multicycle_controller_opcode_decoder
   import multicycle_controller_pkg::*;
(
   input  logic [3:0] opcode,
   output op_class_t  op_class,
   output logic [2:0] alu_op,
   output logic       legal
);

   // Map each opcode to its class; anything unlisted is illegal.
   always_comb begin
      op_class = CL_ILL;
      alu_op   = ALU_AND;
      legal    = 1'b1;
      case (opcode)
         OP_AND:  begin op_class = CL_R;   alu_op = ALU_AND; end
         OP_OR:   begin op_class = CL_R;   alu_op = ALU_OR;  end
         OP_ADD:  begin op_class = CL_R;   alu_op = ALU_ADD; end
         OP_SUB:  begin op_class = CL_R;   alu_op = ALU_SUB; end
         OP_SLT:  begin op_class = CL_R;   alu_op = ALU_SLT; end
         OP_LW:   begin op_class = CL_LW;  alu_op = ALU_ADD; end
         OP_SW:   begin op_class = CL_SW;  alu_op = ALU_ADD; end
         OP_BNE:  begin op_class = CL_BNE; alu_op = ALU_SUB; end
         OP_J:    begin op_class = CL_J;   alu_op = ALU_AND; end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle controller for the 16-bit RISC datapath. Sequences
// FETCH/DECODE/EXEC/MEM/WB with a memory-ready handshake, traps on
// illegal opcodes and counts retired instructions.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int RETW   = 16,
   parameter int PC_INC = 2
) (
   input  logic            clock,
   input  logic            clear,
   input  logic            run,
   input  logic [3:0]      opcode,
   input  logic            eq,
   input  logic            mem_ready,
   output logic            ir_load,
   output logic            pc_write,
   output logic [1:0]      pc_src,
   output logic [2:0]      alu_op,
   output logic            alu_src_imm,
   output logic            mem_read,
   output logic            mem_write,
   output logic            reg_write,
   output logic            wb_sel,
   output logic            busy,
   output logic            illegal,
   output logic [RETW-1:0] retired
);

   // The PC adder in the datapath owns the increment; the controller only
   // selects PC_SEQ, so no logic here depends on the step size.
   if (PC_INC != 2) begin : g_pc_inc_nonstandard
   end

   state_t          state;
   op_class_t       cls_q;
   logic [2:0]      alu_q;
   logic            ill_q;
   logic [RETW-1:0] ret_q;

   op_class_t       dec_class;
   logic [2:0]      dec_alu;
   logic            dec_legal;
   logic            retire;

   multicycle_controller_opcode_decoder u_dec (
      .opcode   (opcode),
      .op_class (dec_class),
      .alu_op   (dec_alu),
      .legal    (dec_legal)
   );

   // An instruction retires on the cycle that heads back toward FETCH.
   always_comb begin
      retire = 1'b0;
      case (state)
         S_EXEC:  retire = (cls_q == CL_BNE) || (cls_q == CL_J);
         S_MEM:   retire = (cls_q == CL_SW) && mem_ready;
         S_WB:    retire = 1'b1;
         default: retire = 1'b0;
      endcase
   end

   // State sequencing, opcode capture, trap flag and retirement counter.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= S_IDLE;
         cls_q <= CL_R;
         alu_q <= ALU_AND;
         ill_q <= 1'b0;
         ret_q <= '0;
      end else begin
         if (retire) ret_q <= ret_q + RETW'(1);
         case (state)
            S_IDLE:   if (run) state <= S_FETCH;
            S_FETCH:  if (mem_ready) state <= S_DECODE;
            S_DECODE: begin
               cls_q <= dec_class;
               alu_q <= dec_alu;
               if (dec_legal) state <= S_EXEC;
               else begin
                  state <= S_TRAP;
                  ill_q <= 1'b1;
               end
            end
            S_EXEC: begin
               if (cls_q == CL_R)                           state <= S_WB;
               else if (cls_q == CL_LW || cls_q == CL_SW)   state <= S_MEM;
               else                                         state <= run ? S_FETCH : S_IDLE;
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (cls_q == CL_LW) state <= S_WB;
                  else                state <= run ? S_FETCH : S_IDLE;
               end
            end
            S_WB:     state <= run ? S_FETCH : S_IDLE;
            S_TRAP:   state <= S_TRAP;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // Datapath controls decoded from the registered state and opcode class.
   // ALU controls stay applied through MEM/WB so the combinational ALU
   // result (address or writeback value) remains stable until retirement.
   always_comb begin
      ir_load     = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PC_SEQ;
      alu_op      = ALU_AND;
      alu_src_imm = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      wb_sel      = 1'b0;
      case (state)
         S_FETCH: ir_load = mem_ready;
         S_EXEC: begin
            alu_op      = alu_q;
            alu_src_imm = (cls_q == CL_LW) || (cls_q == CL_SW);
            if (cls_q == CL_BNE) begin
               pc_write = 1'b1;
               pc_src   = eq ? PC_SEQ : PC_BRANCH;
            end
            if (cls_q == CL_J) begin
               pc_write = 1'b1;
               pc_src   = PC_JUMP;
            end
         end
         S_MEM: begin
            alu_op      = alu_q;
            alu_src_imm = 1'b1;
            mem_read    = (cls_q == CL_LW);
            mem_write   = (cls_q == CL_SW);
            pc_write    = (cls_q == CL_SW) && mem_ready;
         end
         S_WB: begin
            alu_op      = alu_q;
            alu_src_imm = (cls_q == CL_LW);
            reg_write   = 1'b1;
            wb_sel      = (cls_q == CL_LW);
            pc_write    = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy    = (state != S_IDLE);
   assign illegal = ill_q;
   assign retired = ret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes one expected
// control vector per busy cycle, a negedge monitor pops and compares.
// Counter width is reduced to 8 so the wrap case fits a short run.
module tb_multicycle_controller;
   import multicycle_controller_pkg::*;

   localparam int RETW = 8;

   logic            clock = 1'b0;
   logic            clear, run, eq, mem_ready;
   logic [3:0]      opcode;
   logic            ir_load, pc_write, alu_src_imm, mem_read, mem_write;
   logic            reg_write, wb_sel, busy, illegal;
   logic [1:0]      pc_src;
   logic [2:0]      alu_op;
   logic [RETW-1:0] retired;

   multicycle_controller #(.RETW(RETW), .PC_INC(2)) dut (
      .clock(clock), .clear(clear), .run(run), .opcode(opcode), .eq(eq),
      .mem_ready(mem_ready), .ir_load(ir_load), .pc_write(pc_write),
      .pc_src(pc_src), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .wb_sel(wb_sel), .busy(busy), .illegal(illegal), .retired(retired)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic            ir, pw;
      logic [1:0]      ps;
      logic            chk;
      logic [2:0]      ao;
      logic            imm, mr, mw, rw, wb, ill;
      logic [RETW-1:0] ret;
   } exp_t;

   exp_t            q_exp[$];
   string           q_name[$];
   int              tests = 0;
   int              fails = 0;
   logic [RETW-1:0] ret_cnt = '0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, want);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Expected vector for the current cycle; pc_src checked only with pc_write,
   // wb_sel only with reg_write, ALU fields only when chk is set.
   task automatic row(input string nm, input logic ir, pw, input logic [1:0] ps,
                      input logic chk, input logic [2:0] ao,
                      input logic imm, mr, mw, rw, wb, ill);
      exp_t e;
      e.ir = ir; e.pw = pw; e.ps = ps; e.chk = chk; e.ao = ao; e.imm = imm;
      e.mr = mr; e.mw = mw; e.rw = rw; e.wb = wb; e.ill = ill; e.ret = ret_cnt;
      q_exp.push_back(e);
      q_name.push_back(nm);
   endtask

   // One instruction starting in FETCH; xalu is the hand-derived EXEC alu_op.
   task automatic instr(input string nm, input logic [3:0] op, input logic e,
                        input logic [2:0] xalu, input int fstall, input int mstall,
                        input logic stop);
      opcode = op; eq = e;
      for (int i = 0; i < fstall; i++) begin
         mem_ready = 1'b0;
         row({nm, "_fwait"}, 0,0,0, 0,0, 0,0,0,0,0,0); step();
      end
      mem_ready = 1'b1;
      row({nm, "_fetch"}, 1,0,0, 0,0, 0,0,0,0,0,0); step();
      if (stop) run = 1'b0;
      row({nm, "_decode"}, 0,0,0, 0,0, 0,0,0,0,0,0); step();
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: begin
            row({nm, "_exec"}, 0,0,0, 1,xalu, 0,0,0,0,0,0); step();
            row({nm, "_wb"},   0,1,0, 0,0,    0,0,0,1,0,0); step();
            ret_cnt++;
         end
         OP_LW, OP_SW: begin
            row({nm, "_exec"}, 0,0,0, 1,xalu, 1,0,0,0,0,0); step();
            for (int i = 0; i < mstall; i++) begin
               mem_ready = 1'b0;
               row({nm, "_mwait"}, 0,0,0, 0,0, 0,(op == OP_LW),(op == OP_SW),0,0,0); step();
            end
            mem_ready = 1'b1;
            if (op == OP_LW) begin
               row({nm, "_mem"}, 0,0,0, 0,0, 0,1,0,0,0,0); step();
               row({nm, "_wb"},  0,1,0, 0,0, 0,0,0,1,1,0); step();
            end else begin
               row({nm, "_mem"}, 0,1,0, 0,0, 0,0,1,0,0,0); step();
            end
            ret_cnt++;
         end
         OP_BNE: begin
            row({nm, "_exec"}, 0,1,(e ? 2'd0 : 2'd1), 1,xalu, 0,0,0,0,0,0); step();
            ret_cnt++;
         end
         OP_J: begin
            row({nm, "_exec"}, 0,1,2'd2, 0,0, 0,0,0,0,0,0); step();
            ret_cnt++;
         end
         default: begin
            for (int i = 0; i < 20; i++) begin
               run = i[0]; mem_ready = i[1];
               row({nm, "_trap"}, 0,0,0, 0,0, 0,0,0,0,0,1); step();
            end
            mem_ready = 1'b1;
         end
      endcase
   endtask

   // Monitor: every busy cycle must match the next expected vector.
   always @(negedge clock) begin : monitor
      exp_t  e;
      string n;
      logic  ok;
      if (!clear && busy) begin
         tests++;
         if (q_exp.size() == 0) begin
            fails++;
            $display("FAIL unexpected_busy: busy=1 ret=%0d with no expected cycle", retired);
         end else begin
            e = q_exp.pop_front();
            n = q_name.pop_front();
            ok = (ir_load == e.ir) && (pc_write == e.pw) && (!e.pw || pc_src == e.ps) &&
                 (!e.chk || (alu_op == e.ao && alu_src_imm == e.imm)) &&
                 (mem_read == e.mr) && (mem_write == e.mw) && (reg_write == e.rw) &&
                 (!e.rw || wb_sel == e.wb) && (illegal == e.ill) && (retired == e.ret);
            if (!ok) begin
               fails++;
               $display("FAIL %s: got ir=%b pw=%b ps=%0d alu=%0d imm=%b mr=%b mw=%b rw=%b wb=%b ill=%b ret=%0d, expected ir=%b pw=%b ps=%0d alu=%0d imm=%b mr=%b mw=%b rw=%b wb=%b ill=%b ret=%0d",
                        n, ir_load, pc_write, pc_src, alu_op, alu_src_imm, mem_read, mem_write,
                        reg_write, wb_sel, illegal, retired, e.ir, e.pw, e.ps, e.ao, e.imm,
                        e.mr, e.mw, e.rw, e.wb, e.ill, e.ret);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      clear = 1'b1; run = 1'b0; opcode = 4'd0; eq = 1'b0; mem_ready = 1'b1;
      #12;
      check("reset_busy", busy, 0);
      check("reset_illegal", illegal, 0);
      check("reset_retired", retired, 0);
      check("reset_strobes", {ir_load, pc_write, mem_read, mem_write, reg_write}, 0);
      check("reset_pc_src", pc_src, 0);
      check("reset_alu_op", alu_op, 0);
      @(posedge clock); #1;
      clear = 1'b0;
      step();
      check("idle_without_run", busy, 0);

      // main instruction mix
      run = 1'b1; step();
      instr("add", OP_ADD, 0, 3'd2, 0, 0, 0);
      check("add_retired", retired, 1);
      instr("lw_stall", OP_LW, 0, 3'd2, 0, 3, 0);
      instr("bne_ne", OP_BNE, 0, 3'd3, 0, 0, 0);
      instr("bne_eq", OP_BNE, 1, 3'd3, 0, 0, 0);
      instr("and", OP_AND, 0, 3'd0, 0, 0, 0);
      instr("or", OP_OR, 0, 3'd1, 0, 0, 0);
      instr("sub", OP_SUB, 0, 3'd3, 0, 0, 0);
      instr("slt", OP_SLT, 0, 3'd7, 0, 0, 0);
      instr("sw_stall", OP_SW, 0, 3'd2, 0, 1, 0);
      instr("lw", OP_LW, 0, 3'd2, 0, 0, 0);
      instr("add_fwait", OP_ADD, 0, 3'd2, 2, 0, 0);
      instr("j_stop", OP_J, 0, 3'd0, 0, 0, 1);
      check("stop_to_idle", busy, 0);
      check("mix_retired", retired, 12);

      // illegal opcode trap, then clear
      run = 1'b1; step();
      instr("ill3", 4'd3, 0, 3'd0, 0, 0, 0);
      clear = 1'b1; #1;
      check("trap_clear_illegal", illegal, 0);
      check("trap_clear_busy", busy, 0);
      ret_cnt = '0;
      @(posedge clock); #1;
      clear = 1'b0;

      // clear during a stalled SW memory access
      run = 1'b1; step();
      instr("j_pre", OP_J, 0, 3'd0, 0, 0, 0);
      opcode = OP_SW;
      row("swab_fetch", 1,0,0, 0,0, 0,0,0,0,0,0); step();
      row("swab_decode", 0,0,0, 0,0, 0,0,0,0,0,0); step();
      row("swab_exec", 0,0,0, 1,3'd2, 1,0,0,0,0,0); step();
      mem_ready = 1'b0;
      row("swab_mwait", 0,0,0, 0,0, 0,0,1,0,0,0); step();
      check("swab_pre_mem_write", mem_write, 1);
      check("swab_pre_retired", retired, 1);
      clear = 1'b1; run = 1'b0; #1;
      check("swab_mem_write_drop", mem_write, 0);
      check("swab_no_pc_write", pc_write, 0);
      check("swab_busy", busy, 0);
      check("swab_retired_reset", retired, 0);
      ret_cnt = '0;
      @(posedge clock); #1;
      clear = 1'b0; mem_ready = 1'b1;
      step();
      check("swab_after_retired", retired, 0);
      check("swab_after_idle", busy, 0);

      // retirement counter wrap
      run = 1'b1; step();
      for (int k = 0; k < 255; k++) instr("j_wrap", OP_J, 0, 3'd0, 0, 0, 0);
      check("wrap_full", retired, 255);
      instr("j_last", OP_J, 0, 3'd0, 0, 0, 1);
      check("wrap_zero", retired, 0);
      check("wrap_idle", busy, 0);

      step();
      check("queue_drained", q_exp.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
